// File: rtl/fpu_issue_ctrl.sv
// Operand collector and handshake driver for the fpu: gathers a,b,c,d, runs en/fi, returns g.
// Optional ISSUE watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_issue_ctrl #(
  parameter int unsigned W              = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         fpu_en,
  input  logic         fpu_fi,
  output logic [W-1:0] fpu_a,
  output logic [W-1:0] fpu_b,
  output logic [W-1:0] fpu_c,
  output logic [W-1:0] fpu_d,
  input  logic [W-1:0] fpu_g,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         timeout
);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StOut, StRelease} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         in_ready_q, in_ready_d;
  logic         fpu_en_q, fpu_en_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;

`ifdef FPU_TIMEOUT_EN
  localparam logic [15:0]  WdogLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] QNaN     = W'(32'h7FC0_0000);
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    fpu_en_d    = fpu_en_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef FPU_TIMEOUT_EN
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        state_d    = StLoad;
        in_ready_d = 1'b1;
      end
      StLoad: begin
        if (in_valid && in_ready_q) begin
          case (cnt_q)
            2'd0:    a_d = in_data;
            2'd1:    b_d = in_data;
            2'd2:    c_d = in_data;
            default: d_d = in_data;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            in_ready_d = 1'b0;
            fpu_en_d   = 1'b1;
            state_d    = StIssue;
`ifdef FPU_TIMEOUT_EN
            wdog_d     = '0;
`endif
          end
        end
      end
      StIssue: begin
        // A real result on the terminal watchdog cycle takes priority over the abort.
        if (fpu_en_q && fpu_fi) begin
          out_data_d  = fpu_g;
          out_valid_d = 1'b1;
          fpu_en_d    = 1'b0;
          state_d     = StOut;
        end
`ifdef FPU_TIMEOUT_EN
        else if (wdog_q == WdogLast) begin
          out_data_d  = QNaN;
          timeout_d   = 1'b1;
          out_valid_d = 1'b1;
          fpu_en_d    = 1'b0;
          state_d     = StOut;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef FPU_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
          state_d     = StRelease;
        end
      end
      StRelease: begin
        // Hold off the next load until the fpu has dropped fi.
        if (!fpu_fi) begin
          in_ready_d = 1'b1;
          state_d    = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      fpu_en_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef FPU_TIMEOUT_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      fpu_en_q    <= fpu_en_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef FPU_TIMEOUT_EN
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign fpu_en    = fpu_en_q;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign fpu_c     = c_q;
  assign fpu_d     = d_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef FPU_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: table-driven operations, a result scoreboard, and hand sequences
// for stall, reset, timeout and back-to-back cases. Honours FPU_TIMEOUT_EN.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        fpu_en;
  logic        fpu_fi;
  logic [31:0] fpu_a, fpu_b, fpu_c, fpu_d, fpu_g;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        timeout;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .fpu_en    (fpu_en),
    .fpu_fi    (fpu_fi),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_c     (fpu_c),
    .fpu_d     (fpu_d),
    .fpu_g     (fpu_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .timeout   (timeout)
  );

  // fpu stand-in: result depends on operands; test 1 operands give 40A0_0000.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return a ^ b ^ c ^ d ^ 32'h7F60_0000;
  endfunction

  bit         never_fi = 1'b0;
  bit         hold_fi  = 1'b0;
  logic [1:0] fcnt = '0;
  logic       fi_r = 1'b0;

  // fi rises 3 cycles after en, falls once en is low (unless held for the release test).
  always @(posedge clk) begin
    if (hold_fi) fi_r <= 1'b1;
    else if (!fpu_en) begin
      fi_r <= 1'b0;
      fcnt <= '0;
    end else if (!never_fi && !fi_r) begin
      if (fcnt == 2'd2) fi_r <= 1'b1;
      else fcnt <= fcnt + 2'd1;
    end
  end
  assign fpu_fi = fi_r;
  assign fpu_g  = fpu_fn(fpu_a, fpu_b, fpu_c, fpu_d);

  int acc_cnt = 0;
  always @(posedge clk) if (in_valid && in_ready) acc_cnt++;
  int en_low_cnt = 0;
  always @(negedge clk) if (!fpu_en) en_low_cnt++;

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [31:0]      exp;
    logic [7:0]       gap;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input logic [7:0] gap);
    vec_t v;
    v.w[0] = a;
    v.w[1] = b;
    v.w[2] = c;
    v.w[3] = d;
    v.exp  = fpu_fn(a, b, c, d);
    v.gap  = gap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_outputs", {in_ready, fpu_en, out_valid, timeout, out_data}, 64'd0);
    chk("reset_operands", {fpu_a, fpu_b}, 64'd0);
    chk("reset_operands_cd", {fpu_c, fpu_d}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("in_ready_at_release", in_ready, 0);
    @(negedge clk);
    chk("in_ready_first", in_ready, 1);
  endtask

  // Called on a negedge; returns on the negedge after the word was accepted.
  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input bit push);
    exp_t e;
    for (int k = 0; k < 4; k++) send_word(v.w[k], int'(v.gap));
    if (push) begin
      e.data = v.exp;
      e.to   = 1'b0;
      sb_q.push_back(e);
    end
    chk("en_latency", {fpu_en, in_ready}, 2'b10);
    chk("fpu_a", fpu_a, v.w[0]);
    chk("fpu_b", fpu_b, v.w[1]);
    chk("fpu_c", fpu_c, v.w[2]);
    chk("fpu_d", fpu_d, v.w[3]);
  endtask

  task automatic pop_check(output logic [31:0] d);
    exp_t e;
    d = '0;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      d = e.data;
      chk("out_data", out_data, e.data);
      chk("timeout_flag", timeout, e.to);
    end
  endtask

  task automatic wait_result(output logic [31:0] d);
    int n = 0;
    while (!fpu_fi && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("fi_seen", fpu_fi, 1);
    chk("out_valid_pre", out_valid, 0);
    @(negedge clk);
    chk("out_valid_lat", {out_valid, fpu_en}, 2'b10);
    pop_check(d);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_clr", {out_valid, timeout}, 2'b00);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    int a0, n, en_cnt, g0;
    vecs[0] = mk(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 8'd0);
    vecs[1] = mk(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 8'd2);
    vecs[2] = mk(32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h7F80_0000, 8'd1);
    vecs[3] = mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 32'hCAFE_F00D, 8'd3);

    #2;
    @(negedge clk);
    do_reset();

    // Table: basic ops, with and without inter-word gaps.
    for (int i = 0; i < 4; i++) begin
      a0 = acc_cnt;
      run_op(vecs[i], 1'b1);
      wait_result(e);
      handshake();
      chk("accepts_per_op", acc_cnt - a0, 4);
    end

    // Output stall with fi held high: nothing moves until release, LOAD waits for fi low.
    run_op(vecs[1], 1'b1);
    wait_result(e);
    hold_fi = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, e});
    end
    handshake();
    repeat (4) begin
      @(negedge clk);
      chk("release_wait_fi", in_ready, 0);
    end
    hold_fi = 1'b0;
    @(negedge clk);
    chk("release_fi_falling", in_ready, 0);
    @(negedge clk);
    chk("release_to_load", in_ready, 1);

    // in_valid held through ISSUE/OUT: no extra accepts, operands frozen.
    a0 = acc_cnt;
    run_op(vecs[3], 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h1111_2222;
    wait_result(e);
    chk("no_extra_accept", acc_cnt - a0, 4);
    chk("operands_frozen", fpu_d, vecs[3].w[3]);
    in_valid = 1'b0;
    handshake();

    // Reset mid-ISSUE drops fpu_en at once.
    never_fi = 1'b1;
    run_op(vecs[0], 1'b0);
    repeat (2) @(negedge clk);
    chk("en_before_reset", fpu_en, 1);
    do_reset();
    never_fi = 1'b0;

    // Reset after two words: next set starts at slot a.
    send_word(32'hBBBB_0001, 0);
    send_word(32'hBBBB_0002, 0);
    do_reset();
    run_op(vecs[2], 1'b1);
    wait_result(e);
    handshake();

    // fpu never answers.
    never_fi = 1'b1;
    run_op(vecs[3], 1'b0);
`ifdef FPU_TIMEOUT_EN
    sb_q.push_back('{data: 32'h7FC0_0000, to: 1'b1});
    en_cnt = 0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (fpu_en) en_cnt++;
      @(negedge clk);
      n++;
    end
    chk("timeout_out_valid", out_valid, 1);
    chk("timeout_issue_cycles", en_cnt, 8);
    chk("timeout_en_low", fpu_en, 0);
    pop_check(e);
    handshake();
    never_fi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("timeout_back_to_load", in_ready, 1);
`else
    repeat (50) @(negedge clk);
    chk("no_timeout_wait", {fpu_en, out_valid, timeout}, 3'b100);
    do_reset();
    never_fi = 1'b0;
`endif

    // Two back-to-back ops with out_ready tied high.
    out_ready = 1'b1;
    run_op(vecs[0], 1'b1);
    wait_result(e);
    g0 = en_low_cnt;
    run_op(vecs[1], 1'b1);
    chk("en_gap_between_ops", (en_low_cnt - g0) >= 1, 1);
    wait_result(e);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_drained", {out_valid, 32'(sb_q.size())}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
